// File: rtl/cached_ram.sv
// Direct-mapped write-back, write-allocate cache in front of a fixed-latency word RAM.
// Optional hit/miss counters are enabled by defining CACHED_RAM_STATS_EN.
module cached_ram #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned LINES       = 256,
  parameter int unsigned RAM_DEPTH   = 1024,
  parameter int unsigned RAM_LATENCY = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_din,
  output logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_re,
  input  logic                  mem_we,
  output logic                  mem_ready
`ifdef CACHED_RAM_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_WIDTH - IDX_W;
  localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
  localparam int unsigned CNT_W  = $clog2(RAM_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL_REQ,
    S_FILL
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_din;
  logic                  req_wr;

  logic [LINES-1:0]      valid, dirty;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit, victim_dirty;

  logic                  ram_re, ram_we, ram_busy, ram_ready, ram_accept, ram_done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
  logic [CNT_W-1:0]      ram_cnt;
  logic [DATA_WIDTH-1:0] ram_array [RAM_DEPTH] = '{default: '0};

  logic accept, write_line, fill_line, hit_read, issue_wb, issue_fill;

  function automatic logic [RAM_AW-1:0] ram_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] m;
    m = a % ADDR_WIDTH'(RAM_DEPTH);
    return m[RAM_AW-1:0];
  endfunction

  assign idx          = req_addr[IDX_W-1:0];
  assign req_tag      = req_addr[ADDR_WIDTH-1:IDX_W];
  assign hit          = valid[idx] && (tag_mem[idx] == req_tag);
  assign victim_dirty = valid[idx] && dirty[idx];
  assign mem_ready    = (state == S_IDLE);
  assign accept       = mem_ready && (mem_re || mem_we);

  assign ram_ready  = !ram_busy;
  assign ram_accept = ram_ready && (ram_re || ram_we) && !rst;
  assign ram_done   = ram_busy && (ram_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    write_line = 1'b0;
    fill_line  = 1'b0;
    hit_read   = 1'b0;
    issue_wb   = 1'b0;
    issue_fill = 1'b0;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_LOOKUP;
      S_LOOKUP: begin
        if (hit) begin
          write_line = req_wr;
          hit_read   = !req_wr;
          state_nx   = S_IDLE;
        end else if (victim_dirty) begin
          issue_wb = 1'b1;
          state_nx = S_WB;
        end else if (req_wr) begin
          write_line = 1'b1;
          state_nx   = S_IDLE;
        end else begin
          issue_fill = 1'b1;
          state_nx   = S_FILL;
        end
      end
      S_WB: if (ram_done) begin
        write_line = req_wr;
        state_nx   = req_wr ? S_IDLE : S_FILL_REQ;
      end
      // RAM is idle again here, so the fill request can be registered
      S_FILL_REQ: begin
        issue_fill = 1'b1;
        state_nx   = S_FILL;
      end
      S_FILL: if (ram_done) begin
        fill_line = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= mem_addr;
      req_din  <= mem_din;
      req_wr   <= mem_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (write_line) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b1;
    end else if (fill_line) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (write_line) begin
      tag_mem[idx]  <= req_tag;
      data_mem[idx] <= req_din;
    end else if (fill_line) begin
      tag_mem[idx]  <= req_tag;
      data_mem[idx] <= ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            mem_dout <= '0;
    else if (hit_read)  mem_dout <= data_mem[idx];
    else if (fill_line) mem_dout <= ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_re <= 1'b0;
      ram_we <= 1'b0;
    end else begin
      if (ram_accept) begin
        ram_re <= 1'b0;
        ram_we <= 1'b0;
      end
      if (issue_wb) begin
        ram_we    <= 1'b1;
        ram_addr  <= {tag_mem[idx], idx};
        ram_wdata <= data_mem[idx];
      end
      if (issue_fill) begin
        ram_re   <= 1'b1;
        ram_addr <= req_addr;
      end
    end
  end

  // Completion is consumed on the same edge that frees the RAM
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_busy <= 1'b0;
      ram_cnt  <= '0;
    end else if (ram_accept) begin
      ram_busy <= 1'b1;
      ram_cnt  <= CNT_W'(RAM_LATENCY - 1);
    end else if (ram_busy) begin
      ram_cnt <= ram_cnt - CNT_W'(1);
      if (ram_done) ram_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_accept && ram_we) ram_array[ram_index(ram_addr)] <= ram_wdata;
    if (ram_accept && ram_re) ram_rdata <= ram_array[ram_index(ram_addr)];
  end

`ifdef CACHED_RAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit && hit_count != '1)         hit_count  <= hit_count + 32'd1;
      else if (!hit && miss_count != '1)  miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cached_ram.sv
// Self-checking bench for cached_ram: directed scenarios plus random traffic,
// checked against an address-level cache/RAM reference model.
module tb_cached_ram;
  localparam int L = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] mem_addr, mem_din, mem_dout;
  logic        mem_re, mem_we, mem_ready;
`ifdef CACHED_RAM_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  cached_ram #(.RAM_LATENCY(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_ready (mem_ready)
`ifdef CACHED_RAM_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per-line full address, RAM keyed by addr mod 1024
  logic [63:0] ram_m  [1024];
  bit          v_m    [256];
  bit          d_m    [256];
  logic [63:0] la_m   [256];
  logic [63:0] c_m    [256];
  logic [63:0] exp_dout;
  int          hits_m, miss_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) begin
      v_m[i] = 1'b0;
      d_m[i] = 1'b0;
    end
    exp_dout = '0;
    hits_m   = 0;
    miss_m   = 0;
  endfunction

  // Applies one request to the model and returns the expected busy cycles
  function automatic int model_op(input bit wr, input logic [63:0] a, input logic [63:0] d);
    int  i;
    int  lat;
    bit  h;
    i = int'(a % 64'd256);
    h = v_m[i] && (la_m[i] == a);
    if (h) begin
      lat = 1;
      hits_m++;
    end else begin
      miss_m++;
      if (v_m[i] && d_m[i]) begin
        ram_m[int'(la_m[i] % 64'd1024)] = c_m[i];
        lat = wr ? L + 1 : 2 * L + 2;
      end else begin
        lat = wr ? 1 : L + 1;
      end
    end
    if (wr) begin
      v_m[i] = 1'b1; d_m[i] = 1'b1; la_m[i] = a; c_m[i] = d;
    end else begin
      if (!h) begin
        v_m[i] = 1'b1; d_m[i] = 1'b0; la_m[i] = a;
        c_m[i] = ram_m[int'(a % 64'd1024)];
      end
      exp_dout = c_m[i];
    end
    return lat;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!mem_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check({tag, "_ready_timeout"}, 64'(mem_ready), 64'd1);
  endtask

  task automatic do_op(input bit wr, input logic [63:0] a, input logic [63:0] d, input string tag);
    int lat, exp_lat;
    wait_ready(tag);
    exp_lat  = model_op(wr, a, d);
    mem_addr = a;
    mem_din  = d;
    mem_we   = wr;
    mem_re   = !wr;
    @(negedge clk);
    mem_we = 1'b0;
    mem_re = 1'b0;
    lat    = 0;
    while (!mem_ready && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_dout"}, mem_dout, exp_dout);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check({tag, "_ready"}, 64'(mem_ready), 64'd1);
    check({tag, "_dout"}, mem_dout, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_lat;
    for (int i = 0; i < 1024; i++) ram_m[i] = '0;
    model_reset();
    rst = 1'b1; mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_din = '0;
    repeat (3) @(negedge clk);
    do_reset("reset");

    do_op(1'b1, 64'd1, 64'h0123456789abcdef, "w1");
    do_op(1'b0, 64'd1, 64'd0, "r1_hit");
    do_op(1'b1, 64'd257, 64'd123, "w257_dirty_victim");
    do_op(1'b0, 64'd257, 64'd0, "r257_hit");
    do_op(1'b0, 64'd1, 64'd0, "r1_dirty_victim");
    do_op(1'b0, 64'd257, 64'd0, "r257_clean_fill");
    do_op(1'b1, 64'd256, 64'd321, "w256");
    do_op(1'b0, 64'd257, 64'd0, "r257");
    do_op(1'b0, 64'd1, 64'd0, "r1");
    do_op(1'b0, 64'd256, 64'd0, "r256");
    do_op(1'b1, 64'd1, 64'd5, "w1_overwrite");
    do_op(1'b0, 64'd1, 64'd0, "r1_new");
    do_op(1'b0, 64'd257, 64'd0, "r257_again");
    do_op(1'b0, 64'd256, 64'd0, "r256_again");
    do_op(1'b0, 64'd1025, 64'd0, "r1025_alias");

    // Dirty-victim read, ignored pulses while busy, then reset during the fill
    do_op(1'b1, 64'd2, 64'd77, "w2");
    wait_ready("abort");
    exp_lat  = model_op(1'b0, 64'd258, 64'd0);
    mem_addr = 64'd258;
    mem_re   = 1'b1;
    @(negedge clk);
    mem_re = 1'b0;
    repeat (20) @(negedge clk);
    mem_addr = 64'd3; mem_din = 64'hdead; mem_we = 1'b1; mem_re = 1'b1;
    @(negedge clk);
    mem_we = 1'b0; mem_re = 1'b0;
    repeat (130) @(negedge clk);
    check("abort_busy_in_fill", 64'(mem_ready), 64'd0);
    check("abort_expected_lat", 64'(exp_lat), 64'(2 * L + 2));
    do_reset("midfill_reset");
    do_op(1'b0, 64'd1, 64'd0, "r1_after_reset");
    do_op(1'b0, 64'd2, 64'd0, "r2_after_reset");
    do_op(1'b0, 64'd3, 64'd0, "r3_pulse_ignored");

    for (int n = 0; n < 150; n++) begin
      logic [63:0] a, d;
      a = 64'($urandom_range(0, 4)) * 64'd256 + 64'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      do_op(1'($urandom_range(0, 1)), a, d, "rand");
    end

`ifdef CACHED_RAM_STATS_EN
    check("hit_count", 64'(hit_count), 64'(hits_m));
    check("miss_count", 64'(miss_count), 64'(miss_m));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
